seg_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment scan controller that drives NUM_DIGITS common-anode digits from a packed hex-nibble bus. It is the reusable successor to the fixed four-digit display path in the board top level. Over the fixed design it adds:
- double-buffered, tear-free updates through a load/acknowledge handshake;
- per-digit blanking and decimal points;
- optional leading-zero suppression.

It sits between the datapath that produces display values and the board an/seg/dp pins.

---
 rtl/seg_scan_ctrl_if.sv | 38 +++
 rtl/seg_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - display content and pin bundle for seg_scan_ctrl
//
// Purpose: groups the content-loading handshake and the display pins of the
// scan controller so producers and the controller share one typed connection.
// Signals:
//   data      4*NUM_DIGITS  nibble k is the value for digit k (digit 0 rightmost)
//   blank     NUM_DIGITS    bit k forces digit k dark
//   dp_in     NUM_DIGITS    bit k lights the decimal point of digit k
//   load      1             one-cycle strobe capturing data/blank/dp_in
//   lz_en     1             live leading-zero suppression enable
//   load_ack  1             pulse marking that loaded content became visible
//   an        NUM_DIGITS    active-low digit anodes
//   seg       7             active-low segments {G,F,E,D,C,B,A}
//   dp        1             active-low decimal point
// Modports: master = content producer / pin observer, slave = controller.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    lz_en;
  logic                    load_ack;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;

  modport master (
    output data, blank, dp_in, load, lz_en,
    input  load_ack, an, seg, dp
  );

  modport slave (
    input  data, blank, dp_in, load, lz_en,
    output load_ack, an, seg, dp
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - double-buffered multiplexed seven-segment scan controller
//
// Purpose: scans NUM_DIGITS common-anode digits, one digit lit for DIVIDE_BY
// clocks at a time, rightmost digit first. Loaded content is staged and only
// becomes active at a frame boundary so a frame is never torn.
// Ports:
//   clk   system clock, rising edge
//   btnC  synchronous active-low reset
//   bus   seg_scan_ctrl_if slave: data/blank/dp_in/load/lz_en in,
//         load_ack/an/seg/dp out
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIVIDE_BY  = 100000
) (
  input  logic             clk,
  input  logic             btnC,
  seg_scan_ctrl_if.slave   bus
);
  localparam int CW = (DIVIDE_BY > 1) ? $clog2(DIVIDE_BY) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]           divCnt;
  logic [IW-1:0]           idx;
  logic                    tick;
  logic                    frameEnd;

  logic [4*NUM_DIGITS-1:0] stageData;
  logic [NUM_DIGITS-1:0]   stageBlank;
  logic [NUM_DIGITS-1:0]   stageDp;
  logic                    pending;

  logic [4*NUM_DIGITS-1:0] activeData;
  logic [NUM_DIGITS-1:0]   activeBlank;
  logic [NUM_DIGITS-1:0]   activeDp;
  logic                    loadAck;

  assign tick     = (divCnt == CW'(DIVIDE_BY - 1));
  assign frameEnd = tick && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (!btnC) begin
      divCnt      <= '0;
      idx         <= '0;
      stageData   <= '0;
      stageBlank  <= '0;
      stageDp     <= '0;
      pending     <= 1'b0;
      activeData  <= '0;
      activeBlank <= '0;
      activeDp    <= '0;
      loadAck     <= 1'b0;
    end else begin
      divCnt  <= tick ? '0 : divCnt + CW'(1);
      loadAck <= 1'b0;
      if (tick) begin
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
      end

      if (frameEnd && bus.load) begin
        // A load landing on the boundary bypasses staging entirely.
        activeData  <= bus.data;
        activeBlank <= bus.blank;
        activeDp    <= bus.dp_in;
        pending     <= 1'b0;
        loadAck     <= 1'b1;
      end else if (frameEnd && pending) begin
        activeData  <= stageData;
        activeBlank <= stageBlank;
        activeDp    <= stageDp;
        pending     <= 1'b0;
        loadAck     <= 1'b1;
      end else if (bus.load) begin
        stageData   <= bus.data;
        stageBlank  <= bus.blank;
        stageDp     <= bus.dp_in;
        pending     <= 1'b1;
      end
    end
  end

  function automatic logic [6:0] hexGlyph(input logic [3:0] v);
    case (v)
      4'h0: hexGlyph = 7'b1000000;
      4'h1: hexGlyph = 7'b1111001;
      4'h2: hexGlyph = 7'b0100100;
      4'h3: hexGlyph = 7'b0110000;
      4'h4: hexGlyph = 7'b0011001;
      4'h5: hexGlyph = 7'b0010010;
      4'h6: hexGlyph = 7'b0000010;
      4'h7: hexGlyph = 7'b1111000;
      4'h8: hexGlyph = 7'b0000000;
      4'h9: hexGlyph = 7'b0010000;
      4'hA: hexGlyph = 7'b0001000;
      4'hB: hexGlyph = 7'b0000011;
      4'hC: hexGlyph = 7'b1000110;
      4'hD: hexGlyph = 7'b0100001;
      4'hE: hexGlyph = 7'b0000110;
      default: hexGlyph = 7'b0001110;
    endcase
  endfunction

  logic [3:0]            curNibble;
  logic                  curBlank;
  logic                  curDp;
  logic                  upperZero;
  logic [NUM_DIGITS-1:0] anLit;
  logic                  suppress;
  logic                  dark;

  // upperZero: the current nibble and every more-significant nibble are zero.
  always_comb begin
    curNibble = 4'd0;
    curBlank  = 1'b0;
    curDp     = 1'b0;
    upperZero = 1'b1;
    anLit     = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k == int'(idx)) begin
        curNibble = activeData[4*k +: 4];
        curBlank  = activeBlank[k];
        curDp     = activeDp[k];
        anLit[k]  = 1'b0;
      end
      if (k >= int'(idx) && activeData[4*k +: 4] != 4'd0) begin
        upperZero = 1'b0;
      end
    end
  end

  // Digit 0 is exempt so an all-zero value still shows a single 0.
  assign suppress = bus.lz_en && (idx != '0) && upperZero;
  assign dark     = curBlank || suppress;

  assign bus.an       = dark ? '1 : anLit;
  assign bus.seg      = dark ? 7'b1111111 : hexGlyph(curNibble);
  assign bus.dp       = dark ? 1'b1 : ~curDp;
  assign bus.load_ack = loadAck;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;
  localparam int N = 4;
  localparam int D = 2;
  localparam int FRAME = N * D;

  logic clk = 1'b0;
  logic btnC = 1'b0;

  seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  seg_scan_ctrl #(.NUM_DIGITS(N), .DIVIDE_BY(D)) dut (
    .clk (clk),
    .btnC(btnC),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Behavioural model: elapsed cycles since reset plus the two buffers.
  int          tModel = 0;
  logic        modelValid = 1'b0;
  logic [15:0] mActData, mStgData;
  logic [3:0]  mActBlank, mStgBlank, mActDp, mStgDp;
  logic        mPend, mAck;

  always @(posedge clk) begin
    if (!btnC) begin
      tModel = 0;
      mActData = '0; mActBlank = '0; mActDp = '0;
      mStgData = '0; mStgBlank = '0; mStgDp = '0;
      mPend = 1'b0; mAck = 1'b0;
      modelValid = 1'b1;
    end else begin
      mAck = 1'b0;
      if (bus.load) begin
        mStgData = bus.data; mStgBlank = bus.blank; mStgDp = bus.dp_in;
        mPend = 1'b1;
      end
      if ((tModel % FRAME) == FRAME - 1 && mPend) begin
        mActData = mStgData; mActBlank = mStgBlank; mActDp = mStgDp;
        mPend = 1'b0;
        mAck = 1'b1;
      end
      tModel++;
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (modelValid) begin
      int i;
      logic drk;
      logic [3:0] eAn;
      logic [6:0] eSeg;
      logic eDp;
      i = (tModel / D) % N;
      drk = mActBlank[i] || (bus.lz_en && i != 0 && (mActData >> (4 * i)) == 16'd0);
      eAn = drk ? 4'b1111 : ~(4'b0001 << i);
      eSeg = drk ? 7'b1111111 : glyph[(mActData >> (4 * i)) & 16'hF];
      eDp = drk ? 1'b1 : ~mActDp[i];
      checks++;
      if (bus.an !== eAn || bus.seg !== eSeg || bus.dp !== eDp || bus.load_ack !== mAck) begin
        errors++;
        $display("FAIL model t=%0d: got an=%b seg=%b dp=%b ack=%b expected an=%b seg=%b dp=%b ack=%b",
                 tModel, bus.an, bus.seg, bus.dp, bus.load_ack, eAn, eSeg, eDp, mAck);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkLit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic gotoPhase(input int p);
    for (int k = 0; k < FRAME && (tModel % FRAME) != p; k++) cyc();
  endtask

  task automatic loadAt(input int p, input logic [15:0] d, input logic [3:0] b, input logic [3:0] dpi);
    gotoPhase(p);
    bus.data = d; bus.blank = b; bus.dp_in = dpi; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
  endtask

  logic [3:0] expAn1 [10] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011,
                              4'b1011, 4'b0111, 4'b0111, 4'b1110, 4'b1110};
  logic [6:0] seg2 [4] = '{7'b0010010, 7'b0001000, 7'b0110000, 7'b0001110};
  logic [3:0] anSlot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] anLz [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
  logic [6:0] segLz [4] = '{7'b1000000, 7'b0011001, 7'b1111111, 7'b1111111};
  logic [6:0] segNoLz [4] = '{7'b1000000, 7'b0011001, 7'b1000000, 7'b1000000};
  logic [3:0] an6 [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b0111};
  logic       dp6 [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int acks;
    bus.data = '0; bus.blank = '0; bus.dp_in = '0; bus.load = 1'b0; bus.lz_en = 1'b0;

    // 1: reset and scan
    repeat (3) cyc();
    checkLit("reset_an", bus.an, 4'b1110);
    checkLit("reset_seg", bus.seg, 7'b1000000);
    checkLit("reset_dp", bus.dp, 1'b1);
    checkLit("reset_ack", bus.load_ack, 1'b0);
    btnC = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkLit($sformatf("scan_an%0d", i), bus.an, expAn1[i]);
      cyc();
    end

    // 2: single load mid-frame at idx=1
    loadAt(2, 16'hF3A5, 4'b0000, 4'b0000);
    acks = 0;
    for (int k = 0; k < FRAME && (tModel % FRAME) != 0; k++) begin
      checkLit("old_frame_seg", bus.seg, 7'b1000000);
      acks += int'(bus.load_ack);
      cyc();
    end
    for (int i = 0; i < FRAME; i++) begin
      checkLit($sformatf("f3a5_seg%0d", i), bus.seg, seg2[i / D]);
      acks += int'(bus.load_ack);
      cyc();
    end
    checkLit("f3a5_acks", acks, 1);

    // 3: double load, last wins, one ack
    loadAt(1, 16'h1111, 4'b0000, 4'b0000);
    cyc();
    bus.data = 16'h2222; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    acks = 0;
    for (int k = 0; k < FRAME && (tModel % FRAME) != 0; k++) begin
      acks += int'(bus.load_ack);
      cyc();
    end
    for (int i = 0; i < FRAME; i++) begin
      checkLit("double_seg", bus.seg, 7'b0100100);
      acks += int'(bus.load_ack);
      cyc();
    end
    checkLit("double_acks", acks, 1);

    // 4: boundary-cycle load
    loadAt(FRAME - 1, 16'h7777, 4'b0000, 4'b0000);
    checkLit("bnd_seg", bus.seg, 7'b1111000);
    checkLit("bnd_an", bus.an, 4'b1110);
    checkLit("bnd_ack", bus.load_ack, 1'b1);
    cyc();
    checkLit("bnd_ack_drop", bus.load_ack, 1'b0);

    // 5: leading-zero suppression
    bus.lz_en = 1'b1;
    loadAt(FRAME - 1, 16'h0040, 4'b0000, 4'b0000);
    for (int i = 0; i < FRAME; i++) begin
      checkLit("lz_an", bus.an, anLz[i / D]);
      checkLit("lz_seg", bus.seg, segLz[i / D]);
      cyc();
    end
    bus.lz_en = 1'b0;
    #1;
    for (int i = 0; i < FRAME; i++) begin
      checkLit("nolz_an", bus.an, anSlot[i / D]);
      checkLit("nolz_seg", bus.seg, segNoLz[i / D]);
      cyc();
    end
    bus.lz_en = 1'b1;
    loadAt(FRAME - 1, 16'h0000, 4'b0000, 4'b0000);
    for (int i = 0; i < FRAME; i++) begin
      checkLit("zero_an", bus.an, (i < D) ? 4'b1110 : 4'b1111);
      checkLit("zero_seg", bus.seg, (i < D) ? 7'b1000000 : 7'b1111111);
      cyc();
    end
    bus.lz_en = 1'b0;

    // 6: blank, dp, reset with pending
    loadAt(FRAME - 1, 16'h1234, 4'b0100, 4'b0001);
    for (int i = 0; i < FRAME; i++) begin
      checkLit("bdp_an", bus.an, an6[i / D]);
      checkLit("bdp_dp", bus.dp, dp6[i / D]);
      cyc();
    end
    loadAt(2, 16'h5555, 4'b0000, 4'b0000);
    acks = int'(bus.load_ack);
    cyc();
    btnC = 1'b0;
    cyc();
    acks += int'(bus.load_ack);
    cyc();
    checkLit("rst_an", bus.an, 4'b1110);
    checkLit("rst_seg", bus.seg, 7'b1000000);
    checkLit("rst_dp", bus.dp, 1'b1);
    btnC = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      acks += int'(bus.load_ack);
      checkLit("rst_dropped_seg", bus.seg, 7'b1000000);
      cyc();
    end
    checkLit("rst_no_ack", acks, 0);

    // randomized phase, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      btnC = ($urandom_range(299) != 0);
      bus.load = ($urandom_range(5) == 0);
      bus.data = 16'($urandom);
      bus.blank = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
      bus.dp_in = 4'($urandom);
      if ($urandom_range(39) == 0) bus.lz_en = ~bus.lz_en;
      cyc();
    end
    bus.load = 1'b0;
    btnC = 1'b1;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
